// File: rtl/dff_onboth_drv.sv
// dff_onboth_drv: initiator for the three-phase `do` handshake.
// Peer checking is built only when DFF_ONBOTH_DRV_CHECK_EN is defined.
module dff_onboth_drv #(
  parameter int LEN_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             do_o,
  input  logic             peer_g,
  input  logic             peer_x,
  input  logic             peer_f,
  input  logic             peer_r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code
);

  localparam int GW = $clog2(GAP_CYC + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_RELEASE,
    S_LAST_CHK,
    S_TAIL,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_cnt;
  logic [GW-1:0]    r_gcnt;
  logic             r_do;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;

  assign w_accept = (r_state == S_IDLE) && start
                  && (len != '0);

  // next-state decode for the burst sequence
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (r_cnt == '0) w_next = S_RELEASE;
      end
      S_RELEASE:  w_next = S_LAST_CHK;
      S_LAST_CHK: w_next = S_TAIL;
      S_TAIL: begin
        if (GAP_CYC > 0) w_next = S_GAP;
        else             w_next = S_IDLE;
      end
      S_GAP: begin
        if (r_gcnt == GW'(GAP_CYC - 1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // burst length counter, loaded with len-1 on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= len - 1'b1;
    end else if (r_state == S_DRIVE
                 && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // gap counter, cleared while in TAIL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gcnt <= '0;
    end else if (r_state == S_TAIL) begin
      r_gcnt <= '0;
    end else if (r_state == S_GAP) begin
      r_gcnt <= r_gcnt + 1'b1;
    end
  end

  // do/busy follow the next state; done marks entry into TAIL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_do   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_do   <= (w_next == S_DRIVE);
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_LAST_CHK);
    end
  end

  assign do_o = r_do;
  assign busy = r_busy;
  assign done = r_done;

`ifdef DFF_ONBOTH_DRV_CHECK_EN
  logic       r_first;
  logic       r_err;
  logic [2:0] r_code;
  logic       w_fail;
  logic [2:0] w_fcode;

  // per-state protocol check of the responder
  always_comb begin
    w_fail  = 1'b0;
    w_fcode = 3'd0;
    unique case (r_state)
      S_DRIVE: begin
        if (r_first && !peer_g) begin
          w_fail  = 1'b1;
          w_fcode = 3'd1;
        end else if (!r_first && !peer_r) begin
          w_fail  = 1'b1;
          w_fcode = 3'd2;
        end
      end
      S_RELEASE: begin
        if (!peer_x) begin
          w_fail  = 1'b1;
          w_fcode = 3'd3;
        end else if (!peer_r) begin
          w_fail  = 1'b1;
          w_fcode = 3'd2;
        end
      end
      S_LAST_CHK: begin
        if (!(peer_f && peer_g)) begin
          w_fail  = 1'b1;
          w_fcode = 3'd4;
        end
      end
      S_TAIL: begin
        if (!peer_r) begin
          w_fail  = 1'b1;
          w_fcode = 3'd5;
        end
      end
      default: begin
        w_fail  = 1'b0;
        w_fcode = 3'd0;
      end
    endcase
  end

  // first-DRIVE-cycle marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_first <= 1'b0;
    else if (w_accept) r_first <= 1'b1;
    else               r_first <= 1'b0;
  end

  // sticky error, first code per burst wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_code <= 3'd0;
    end else if (w_accept) begin
      r_err  <= 1'b0;
      r_code <= 3'd0;
    end else if (w_fail && !r_err) begin
      r_err  <= 1'b1;
      r_code <= w_fcode;
    end
  end

  assign err      = r_err;
  assign err_code = r_code;
`else
  logic w_unused;
  assign w_unused = &{1'b0, peer_g, peer_x,
                      peer_f, peer_r};
  assign err      = 1'b0;
  assign err_code = 3'd0;
`endif

endmodule

// File: doc/dff_onboth_drv.md
Name: dff_onboth_drv

Overview:
Initiator/driver for the three-phase `do` handshake: IDLE→RUN→LAST→IDLE on the responder side.
- Generates a `do` burst of programmable length.
- Checks every responder output (g, x, f, r) against the protocol cycle by cycle.
- Reports completion and a first-failure error code.
- Sits beside a responder FSM in benches and in integration as the protocol master.

Parameters:
LEN_W, 8, width of burst length input and internal counter
GAP_CYC, 2, idle cycles enforced after each burst before a new start is accepted (0 allowed)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request burst; sampled in IDLE only
len  input  LEN_W  burst length in cycles of do high; sampled with start
do_o  output  1  registered `do` to responder
peer_g  input  1  responder g (combinational pulse on IDLE→RUN and LAST→IDLE)
peer_x  input  1  responder x (combinational pulse on RUN→LAST)
peer_f  input  1  responder f (registered, high while responder in LAST)
peer_r  input  1  responder r (registered, high while in RUN and one cycle after LAST)
busy  output  1  registered; high from first do cycle through last GAP cycle
done  output  1  registered one-cycle pulse at end of burst
err  output  1  registered, sticky; cleared on next accepted start
err_code  output  3  first failure: 0 none, 1 NO_ACK, 2 RUN_LOST, 3 NO_X, 4 NO_LAST, 5 NO_TAIL

Behaviour:
- Reset (rst_n asynchronous, active-low; clock clk): state IDLE; do_o, busy, done, err = 0; err_code = 0; counters = 0. Reset mid-burst aborts immediately with do_o = 0 and no done.
- States: IDLE, DRIVE, RELEASE, LAST_CHK, TAIL, GAP.
- Cycle numbering: start accepted at cycle T.
- IDLE:
  - start=1 and len!=0 → DRIVE; load cnt = len-1; clear err and err_code.
  - start=1 with len==0 is ignored: no state change, no pulse.
- DRIVE, cycles T+1..T+len:
  - do_o=1, busy=1.
  - First DRIVE cycle: peer_g must be 1, else code 1 (NO_ACK).
  - Later DRIVE cycles: peer_r must be 1, else code 2.
  - cnt decrements each cycle; at cnt==0 → RELEASE.
- RELEASE, cycle T+len+1:
  - do_o=0.
  - Requires peer_x=1 (else code 3) and peer_r=1 (else code 2).
  - Unconditional → LAST_CHK.
- LAST_CHK, cycle T+len+2:
  - Requires peer_f=1 and peer_g=1, else code 4.
  - → TAIL.
- TAIL, cycle T+len+3:
  - Requires peer_r=1, else code 5.
  - done=1 this cycle; done is set on transition into TAIL.
  - → GAP if GAP_CYC>0, else IDLE.
- GAP: busy=1 for GAP_CYC cycles, then IDLE. start is ignored outside IDLE; there is no queuing.
- Error handling:
  - Failures never alter sequence timing.
  - err rises the cycle after the first failed check.
  - err_code latches only the first failure per burst.
- Output styles:
  - do_o and busy: registered on nextstate.
  - done and err: registered on transition.
- Counter: LEN_W bits, no wrap. len = 2^LEN_W-1 gives that many do cycles.

Optional Feature:
DFF_ONBOTH_DRV_CHECK_EN
- Defined: all peer checks, err and err_code active as above.
- Undefined: check logic removed; err and err_code tied to 0; peer_* inputs unused.
- do_o, busy and done timing are identical in both builds.

Test Plan:
- len=1, compliant responder, GAP_CYC=2 → do_o high exactly T+1; done at T+4; busy T+1..T+6; err=0.
- len=3, compliant → do_o high T+1..T+3; peer_x seen T+4; done T+6; err_code=0.
- len=2, responder forced to hold g=0 at T+1 → err=1 at T+2; err_code=1; done still at T+5.
- len=0 start → no state change; do_o, busy, done stay 0. Then start during busy of a len=4 burst → ignored, exactly one done.
- len=5, rst_n low at T+3 → do_o=0 asynchronously; no done; after release a new len=1 start completes normally.
- len=255 (LEN_W=8) → do_o high exactly 255 cycles, then done at T+258.
